// File: rtl/registro_eliminacao.sv
// rtl/registro_eliminacao.sv - alive mask, wolf night votes and night elimination
//
// Ports:
//   clock, reset (async, active-low)   clocking and power-on reset
//   rst_global                         synchronous full clear from the controller
//   zera_votos                         clears the night's votes and last result (OCIOSO only)
//   jogador_atual, lobos               current player index and wolf role mask
//   processar_acao, alvo, alvo_valido  night action window, target and its confirm pulse
//   avaliar_eliminacao                 request to resolve the night
//   jogador_vivo, vivos                alive flag of the current player and full alive mask
//   morto_valido, morto_idx            last resolution result
//   resultado_pronto                   one-cycle pulse while the result is applied
//   lobos_vencem, aldeia_vence         game-over flags

module registro_eliminacao #(
  parameter int N_JOG = 8,
  parameter int W     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rst_global,
  input  logic             zera_votos,
  input  logic [W-1:0]     jogador_atual,
  input  logic [N_JOG-1:0] lobos,
  input  logic             processar_acao,
  input  logic [W-1:0]     alvo,
  input  logic             alvo_valido,
  input  logic             avaliar_eliminacao,
  output logic             jogador_vivo,
  output logic [N_JOG-1:0] vivos,
  output logic             morto_valido,
  output logic [W-1:0]     morto_idx,
  output logic             resultado_pronto,
  output logic             lobos_vencem,
  output logic             aldeia_vence
);

  typedef enum logic [1:0] {OCIOSO, VARRE, APLICA} estado_t;

  estado_t          r_estado;
  estado_t          w_prox;
  logic [N_JOG-1:0] r_vivos;
  logic [N_JOG-1:0] r_votou;
  logic [W:0]       r_votos [N_JOG];
  logic [W-1:0]     r_i;
  logic [W:0]       r_max;
  logic [W-1:0]     r_idx_max;
  logic             r_empate;
  logic             r_morto_valido;
  logic [W-1:0]     r_morto_idx;

  logic             w_atual_lobo;
  logic             w_atual_vivo;
  logic             w_atual_votou;
  logic             w_alvo_vivo;
  logic [W:0]       w_cand;
  logic             w_aceita;
  logic             w_zera;
  logic             w_mata;
  logic [W:0]       w_l;
  logic [W:0]       w_a;

  // Index decodes by comparison so that indices >= N_JOG simply match nothing.
  always_comb begin
    w_atual_lobo  = 1'b0;
    w_atual_vivo  = 1'b0;
    w_atual_votou = 1'b0;
    w_alvo_vivo   = 1'b0;
    w_cand        = '0;
    for (int i = 0; i < N_JOG; i++) begin
      if (jogador_atual == W'(i)) begin
        w_atual_lobo  = lobos[i];
        w_atual_vivo  = r_vivos[i];
        w_atual_votou = r_votou[i];
      end
      if (alvo == W'(i)) w_alvo_vivo = r_vivos[i];
      if (r_i == W'(i))  w_cand      = r_votos[i];
    end
  end

  assign w_aceita = (r_estado == OCIOSO) && processar_acao && alvo_valido &&
                    w_atual_lobo && w_atual_vivo && w_alvo_vivo && !w_atual_votou;
  assign w_zera   = (r_estado == OCIOSO) && zera_votos;
  assign w_mata   = (r_max != '0) && !r_empate;

  always_comb begin
    w_prox           = r_estado;
    resultado_pronto = 1'b0;
    case (r_estado)
      OCIOSO: if (avaliar_eliminacao) w_prox = VARRE;
      VARRE:  if (r_i == W'(N_JOG - 1)) w_prox = APLICA;
      APLICA: begin
        w_prox           = OCIOSO;
        // A concurrent global clear discards the result, so no pulse either.
        resultado_pronto = !rst_global;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado       <= OCIOSO;
      r_vivos        <= '1;
      r_votou        <= '0;
      r_i            <= '0;
      r_max          <= '0;
      r_idx_max      <= '0;
      r_empate       <= 1'b0;
      r_morto_valido <= 1'b0;
      r_morto_idx    <= '0;
      for (int i = 0; i < N_JOG; i++) r_votos[i] <= '0;
    end else if (rst_global) begin
      r_estado       <= OCIOSO;
      r_vivos        <= '1;
      r_votou        <= '0;
      r_i            <= '0;
      r_max          <= '0;
      r_idx_max      <= '0;
      r_empate       <= 1'b0;
      r_morto_valido <= 1'b0;
      r_morto_idx    <= '0;
      for (int i = 0; i < N_JOG; i++) r_votos[i] <= '0;
    end else begin
      r_estado <= w_prox;
      case (r_estado)
        OCIOSO: begin
          // The clear beats a vote arriving in the same cycle.
          if (w_zera) begin
            r_votou        <= '0;
            r_morto_valido <= 1'b0;
            r_morto_idx    <= '0;
            for (int i = 0; i < N_JOG; i++) r_votos[i] <= '0;
          end else if (w_aceita) begin
            for (int i = 0; i < N_JOG; i++) begin
              if (alvo == W'(i))          r_votos[i] <= r_votos[i] + 1'b1;
              if (jogador_atual == W'(i)) r_votou[i] <= 1'b1;
            end
          end
          if (avaliar_eliminacao) begin
            r_i       <= '0;
            r_max     <= '0;
            r_idx_max <= '0;
            r_empate  <= 1'b0;
          end
        end
        VARRE: begin
          if (w_cand > r_max) begin
            r_max     <= w_cand;
            r_idx_max <= r_i;
            r_empate  <= 1'b0;
          end else if ((w_cand == r_max) && (r_max != '0)) begin
            r_empate <= 1'b1;
          end
          r_i <= r_i + 1'b1;
        end
        APLICA: begin
          if (w_mata) begin
            for (int i = 0; i < N_JOG; i++)
              if (r_idx_max == W'(i)) r_vivos[i] <= 1'b0;
            r_morto_valido <= 1'b1;
            r_morto_idx    <= r_idx_max;
          end else begin
            r_morto_valido <= 1'b0;
            r_morto_idx    <= '0;
          end
          r_votou <= '0;
          for (int i = 0; i < N_JOG; i++) r_votos[i] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Alive wolves versus alive villagers.
  always_comb begin
    w_l = '0;
    w_a = '0;
    for (int i = 0; i < N_JOG; i++) begin
      if (r_vivos[i]) begin
        if (lobos[i]) w_l = w_l + 1'b1;
        else          w_a = w_a + 1'b1;
      end
    end
  end

  assign aldeia_vence = (w_l == '0);
  assign lobos_vencem = (w_l != '0) && (w_l >= w_a);
  assign jogador_vivo = w_atual_vivo;
  assign vivos        = r_vivos;
  assign morto_valido = r_morto_valido;
  assign morto_idx    = r_morto_idx;

endmodule

// File: tb/tb_registro_eliminacao.sv
// tb/tb_registro_eliminacao.sv - randomized self-checking bench for registro_eliminacao
module tb_registro_eliminacao;
  localparam int N = 8;
  localparam int W = 3;

  logic         clock = 1'b0;
  logic         reset, rst_global, zera_votos;
  logic [W-1:0] jogador_atual, alvo;
  logic [N-1:0] lobos;
  logic         processar_acao, alvo_valido, avaliar_eliminacao;
  logic         jogador_vivo;
  logic [N-1:0] vivos;
  logic         morto_valido;
  logic [W-1:0] morto_idx;
  logic         resultado_pronto, lobos_vencem, aldeia_vence;

  registro_eliminacao #(.N_JOG(N), .W(W)) dut (
    .clock(clock), .reset(reset), .rst_global(rst_global), .zera_votos(zera_votos),
    .jogador_atual(jogador_atual), .lobos(lobos), .processar_acao(processar_acao),
    .alvo(alvo), .alvo_valido(alvo_valido), .avaliar_eliminacao(avaliar_eliminacao),
    .jogador_vivo(jogador_vivo), .vivos(vivos), .morto_valido(morto_valido),
    .morto_idx(morto_idx), .resultado_pronto(resultado_pronto),
    .lobos_vencem(lobos_vencem), .aldeia_vence(aldeia_vence)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game state as plain arrays and counts.
  bit m_alive [N];
  int m_votes [N];
  bit m_voted [N];
  bit m_mv;
  int m_mi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < N; i++) begin
      m_alive[i] = 1'b1; m_votes[i] = 0; m_voted[i] = 1'b0;
    end
    m_mv = 1'b0; m_mi = 0;
  endtask

  task automatic model_zera();
    for (int i = 0; i < N; i++) begin
      m_votes[i] = 0; m_voted[i] = 1'b0;
    end
    m_mv = 1'b0; m_mi = 0;
  endtask

  task automatic model_vote(input int p, input int t);
    if (p < N && t < N && lobos[p] && m_alive[p] && m_alive[t] && !m_voted[p]) begin
      m_votes[t]++;
      m_voted[p] = 1'b1;
    end
  endtask

  task automatic model_resolve();
    int mx, cnt, who;
    mx = 0; cnt = 0; who = 0;
    for (int i = 0; i < N; i++) if (m_votes[i] > mx) mx = m_votes[i];
    for (int i = 0; i < N; i++) if (mx > 0 && m_votes[i] == mx) begin cnt++; who = i; end
    if (cnt == 1) begin
      m_alive[who] = 1'b0; m_mv = 1'b1; m_mi = who;
    end else begin
      m_mv = 1'b0; m_mi = 0;
    end
    for (int i = 0; i < N; i++) begin m_votes[i] = 0; m_voted[i] = 1'b0; end
  endtask

  task automatic check_state(input string tag);
    logic [N-1:0] ev;
    int l, a, p;
    l = 0; a = 0; ev = '0;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_alive[i];
      if (m_alive[i]) begin
        if (lobos[i]) l++; else a++;
      end
    end
    check({tag, "/vivos"}, vivos, ev);
    check({tag, "/morto_valido"}, morto_valido, m_mv);
    check({tag, "/morto_idx"}, morto_idx, m_mi);
    check({tag, "/aldeia_vence"}, aldeia_vence, l == 0);
    check({tag, "/lobos_vencem"}, lobos_vencem, (l > 0) && (l >= a));
    p = $urandom_range(0, N - 1);
    jogador_atual = W'(p);
    #1;
    check({tag, "/jogador_vivo"}, jogador_vivo, m_alive[p]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rst_global = 1'b0; zera_votos = 1'b0; processar_acao = 1'b0;
    alvo_valido = 1'b0; avaliar_eliminacao = 1'b0; jogador_atual = '0; alvo = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    model_clear_all();
  endtask

  task automatic vote(input int p, input int t);
    jogador_atual = W'(p); alvo = W'(t);
    processar_acao = 1'b1; alvo_valido = 1'b1;
    @(negedge clock);
    processar_acao = 1'b0; alvo_valido = 1'b0;
    model_vote(p, t);
  endtask

  task automatic zera();
    zera_votos = 1'b1;
    @(negedge clock);
    zera_votos = 1'b0;
    model_zera();
  endtask

  // mode: 0 plain, 1 vote in same cycle, 2 zera in same cycle.
  // mid: pulse zera and avaliar during the scan (both must be ignored).
  task automatic resolve(input string tag, input int mode, input int p, input int t, input bit mid);
    int lat, pulses;
    if (mode == 1) begin
      jogador_atual = W'(p); alvo = W'(t); processar_acao = 1'b1; alvo_valido = 1'b1;
    end
    if (mode == 2) zera_votos = 1'b1;
    avaliar_eliminacao = 1'b1;
    @(negedge clock);
    avaliar_eliminacao = 1'b0; zera_votos = 1'b0; processar_acao = 1'b0; alvo_valido = 1'b0;
    if (mode == 1) model_vote(p, t);
    if (mode == 2) model_zera();
    model_resolve();
    lat = 0; pulses = 0;
    for (int k = 1; k <= N + 4; k++) begin
      if (mid && k == 2) begin zera_votos = 1'b1; avaliar_eliminacao = 1'b1; end
      @(negedge clock);
      zera_votos = 1'b0; avaliar_eliminacao = 1'b0;
      if (resultado_pronto === 1'b1) begin
        pulses++;
        if (lat == 0) lat = k + 1;
      end
    end
    check({tag, "/latency"}, lat, N + 1);
    check({tag, "/pulses"}, pulses, 1);
    check_state(tag);
  endtask

  task automatic expect_no_pulse(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (resultado_pronto !== 1'b0) pulses++;
    end
    check({tag, "/no_pulse"}, pulses, 0);
  endtask

  initial begin
    lobos = 8'b0000_0011;
    do_reset();
    check("reset/pronto", resultado_pronto, 0);
    check_state("reset");

    vote(0, 5); vote(1, 5);
    resolve("kill5", 0, 0, 0, 1'b0);
    check("kill5/vivos_const", vivos, 8'hDF);

    zera();
    check_state("zera");
    vote(0, 4); vote(1, 6);
    resolve("tie", 0, 0, 0, 1'b0);
    resolve("novotes", 0, 0, 0, 1'b0);

    vote(3, 2); vote(0, 2); vote(0, 2); vote(1, 5);
    resolve("illegal", 0, 0, 0, 1'b0);
    check("illegal/vivos_const", vivos, 8'hDB);

    for (int v = 3; v <= 6; v++) begin
      vote(0, v);
      resolve("nights", 0, 0, 0, 1'b1);
    end
    check("nights/lobos_vencem", lobos_vencem, 1);

    do_reset();
    vote(0, 0); vote(1, 0);
    resolve("wolf0", 0, 0, 0, 1'b0);
    resolve("wolf1", 1, 1, 1, 1'b0);
    check("wolves_dead/aldeia", aldeia_vence, 1);

    do_reset();
    vote(0, 5); vote(1, 5);
    avaliar_eliminacao = 1'b1;
    @(negedge clock);
    avaliar_eliminacao = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_rst/vivos", vivos, 8'hFF);
    check("abort_rst/pronto", resultado_pronto, 0);
    @(negedge clock);
    reset = 1'b1;
    model_clear_all();
    expect_no_pulse("abort_rst", N + 3);
    check_state("abort_rst");

    vote(0, 5); vote(1, 5);
    avaliar_eliminacao = 1'b1;
    @(negedge clock);
    avaliar_eliminacao = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst_global = 1'b1;
    @(negedge clock);
    rst_global = 1'b0;
    model_clear_all();
    expect_no_pulse("abort_glob", N + 3);
    check_state("abort_glob");

    for (int g = 0; g < 20; g++) begin
      lobos = N'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_reset();
      end else begin
        rst_global = 1'b1;
        @(negedge clock);
        rst_global = 1'b0;
        model_clear_all();
      end
      check_state("rnd_reset");
      for (int n = 0; n < 5; n++) begin
        int nv, mode;
        nv = $urandom_range(0, 6);
        for (int j = 0; j < nv; j++) vote($urandom_range(0, N - 1), $urandom_range(0, N - 1));
        if ($urandom_range(0, 5) == 0) zera();
        mode = $urandom_range(0, 2);
        resolve("rnd", mode, $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                $urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/registro_eliminacao.md
# registro_eliminacao

Tracks which players are alive, collects the wolves' night votes, and resolves the night elimination for the game controller. It sits directly downstream of the controller, consuming `processar_acao`, `avaliar_eliminacao`, `zera_CJ` and `rst_global`. It also feeds `jogador_vivo` back to the controller's `CHECAR_VIVO` state. Targets come from the input converter, and the role mask comes from the seed/role assigner.

## Interface
Parameters:
- `N_JOG`, default 8: number of players, 2..16.
- `W`, default 3: player index width, equal to clog2(`N_JOG`).

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rst_global`  in  1  synchronous clear from the controller; active-high.
- `zera_votos`  in  1  synchronous clear of the night's votes; driven by the controller's `zera_CJ`.
- `jogador_atual`  in  `W`  index of the player whose turn it is (CJ count).
- `lobos`  in  `N_JOG`  role mask; bit i = 1 means player i is a wolf. Stable after game setup.
- `processar_acao`  in  1  high while the current player's night turn is active.
- `alvo`  in  `W`  target selected by the current player.
- `alvo_valido`  in  1  one-cycle pulse confirming `alvo`.
- `avaliar_eliminacao`  in  1  one-cycle request to resolve the night.
- `jogador_vivo`  out  1  equals `vivos[jogador_atual]` (combinational).
- `vivos`  out  `N_JOG`  alive mask.
- `morto_valido`  out  1  a player died in the last resolution.
- `morto_idx`  out  `W`  index of the dead player; 0 when `morto_valido` = 0.
- `resultado_pronto`  out  1  one-cycle pulse marking the resolution as complete.
- `lobos_vencem`  out  1  game over, wolves win.
- `aldeia_vence`  out  1  game over, village wins.

## Operation
State machine with three states: OCIOSO, VARRE, APLICA.

Reset and clear:
- On `reset` = 0 (asynchronous), and on `rst_global` = 1 (synchronous):
  - `vivos` = all ones.
  - All vote counters, the `votou` mask and `morto_valido`/`morto_idx` = 0.
  - State = OCIOSO.
- `rst_global` has priority over every other input.

Vote acceptance:
- Accepted only in OCIOSO, when all of the following hold:
  - `processar_acao` && `alvo_valido`;
  - `lobos[jogador_atual]` && `vivos[jogador_atual]`;
  - `vivos[alvo]` && !`votou[jogador_atual]`.
- On acceptance: `votos[alvo]` += 1 and `votou[jogador_atual]` = 1.
- Every other pulse is silently ignored. This covers villagers, dead players, dead targets, repeat votes, and `alvo` ≥ `N_JOG`.
- Counters are `W`+1 bits wide. They cannot overflow because each player casts at most one vote per night.

Vote clearing:
- `zera_votos` clears `votos`, `votou`, `morto_valido` and `morto_idx`.
- It does not touch `vivos`.
- It is ignored outside OCIOSO.

Resolution:
- `avaliar_eliminacao` in OCIOSO moves the state to VARRE with scan index i = 0, max = 0, and the tie flag cleared.
- `avaliar_eliminacao` in any other state is ignored.
- VARRE, one candidate per cycle for i = 0..`N_JOG`-1:
  - `votos[i]` > max: max = `votos[i]`, idx = i, tie = 0.
  - `votos[i]` == max and max > 0: tie = 1.
  - After i = `N_JOG`-1, go to APLICA.
- APLICA lasts one cycle:
  - If max > 0 and !tie: clear `vivos[idx]`, set `morto_valido` = 1, `morto_idx` = idx.
  - Otherwise (no votes, or a tie): nobody dies and `morto_valido` = 0.
  - `resultado_pronto` = 1.
  - Clear `votos` and `votou`.
  - Return to OCIOSO.
- `morto_valido`/`morto_idx` hold until the next `zera_votos`, `rst_global` or `reset`.

Win detection (combinational from `vivos` and `lobos`):
- L = popcount(`vivos` & `lobos`); A = popcount(`vivos` & ~`lobos`).
- `aldeia_vence` = (L == 0).
- `lobos_vencem` = (L > 0) && (L ≥ A).

## Timing
- Reset values:
  - `vivos` = all ones.
  - `morto_valido` = 0, `morto_idx` = 0, `resultado_pronto` = 0.
  - `jogador_vivo` = 1.
  - `aldeia_vence` = 1 if `lobos` == 0, otherwise 0.
  - `lobos_vencem` follows its formula applied to the `lobos` mask.
- An accepted vote is visible in the counter on the cycle after the `alvo_valido` edge.
- `avaliar_eliminacao` sampled high at edge t:
  - VARRE occupies edges t+1 .. t+`N_JOG`.
  - APLICA follows at edge t+`N_JOG`+1, where `resultado_pronto` is high for exactly that one cycle.
  - `vivos`, `morto_*` and the win flags are updated from edge t+`N_JOG`+2.
  - The controller's `ANUNCIAR_MORTE` waits for a human `passa`, so this latency is hidden.
- Simultaneous `alvo_valido` and `avaliar_eliminacao` in OCIOSO: the vote is counted first, and the scan sees it.
- `zera_votos` and `avaliar_eliminacao` in the same cycle: the clear wins, and the resolution finds no votes.
- `reset` asserted mid-VARRE aborts the scan immediately. No player dies and no `resultado_pronto` pulse is produced.

## Test plan
- Reset, `lobos` = 8'b0000_0011 → `vivos` = 8'hFF, `jogador_vivo` = 1, `morto_valido` = 0, `lobos_vencem` = 0, `aldeia_vence` = 0.
- Wolves 0 and 1 both vote `alvo` = 5, then `avaliar_eliminacao` → `resultado_pronto` at cycle +9, `vivos` = 8'hDF, `morto_valido` = 1, `morto_idx` = 5.
- Wolf 0 votes 4 and wolf 1 votes 6 (a tie), and separately the case with no votes at all → `vivos` unchanged, `morto_valido` = 0, `resultado_pronto` still pulses.
- Illegal votes: villager 3 votes 2, wolf 0 votes twice for 2, and a vote targets dead player 5 → only the first vote from wolf 0 counts; the result kills 2.
- Kill players 2..6 over successive nights (A = 1, L = 2) → `lobos_vencem` = 1. Separately, set `vivos` so both wolves are dead → `aldeia_vence` = 1.
- Assert `reset` at the 3rd VARRE cycle, and separately `rst_global` → state OCIOSO, `vivos` = 8'hFF, no `resultado_pronto`.
